// File: rtl/tdm_demux_pair.sv
// tdm_demux_pair: splits a lane-tagged word stream into {a,b} pairs under valid/ready.
// Optional sticky overwrite flag port err when TDM_DEMUX_ERR_EN is defined.
module tdm_demux_pair #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] y,
    input  logic         s,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] a,
    output logic [W-1:0] b,
    output logic         out_valid,
`ifdef TDM_DEMUX_ERR_EN
    output logic         err,
`endif
    input  logic         out_ready
);
    typedef enum logic [1:0] {EMPTY, HAVE_A, HAVE_B, FULL} state_t;
    state_t state;
    logic   take;
    logic   cons;
    assign out_valid = state == FULL;
    assign in_ready  = (state != FULL) || out_ready;
    assign take      = in_valid && in_ready;
    assign cons      = out_valid && out_ready;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
            a     <= '0;
            b     <= '0;
        end else begin
            if (take && !s) a <= y;
            if (take && s) b <= y;
            case (state)
                EMPTY:   state <= take ? (s ? HAVE_B : HAVE_A) : EMPTY;
                HAVE_A:  state <= (take && s) ? FULL : HAVE_A;
                HAVE_B:  state <= (take && !s) ? FULL : HAVE_B;
                default: state <= cons ? (take ? (s ? HAVE_B : HAVE_A) : EMPTY) : FULL;
            endcase
        end
    end
`ifdef TDM_DEMUX_ERR_EN
    // A same-lane word while the other lane is still missing discards a word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err <= 1'b0;
        else if (take && ((state == HAVE_A && !s) || (state == HAVE_B && s))) err <= 1'b1;
    end
`endif
endmodule
